// File: rtl/logic_op_issuer.sv
// logic_op_issuer: buffers AND/OR commands in a 4-entry FIFO and issues them
// one at a time to a combinational and_or stage. Each result is captured
// and held until the consumer takes it. Illegal opcodes are flagged and
// counted in a saturating error counter.
module logic_op_issuer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdOp,
  input  logic [3:0] cmdA,
  input  logic [3:0] cmdB,
  output logic [3:0] aIn,
  output logic [3:0] bIn,
  output logic       doAnd,
  output logic       doOr,
  input  logic [3:0] stageOut,
  input  logic       stageIsAnd,
  output logic       resValid,
  input  logic       resReady,
  output logic [3:0] resData,
  output logic       resIsAnd,
  output logic       resErr,
  output logic [7:0] errCount
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Opcodes 00 and 11 carry no meaningful select for the stage.
  function automatic logic is_illegal_op(input logic [1:0] op);
    return (op[0] == op[1]);
  endfunction

  logic [1:0] state_q, state_d;
  logic [9:0] fifo_q [4];
  logic [9:0] fifo_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [3:0] res_data_q, res_data_d;
  logic       res_is_and_q, res_is_and_d;
  logic       res_err_q, res_err_d;
  logic [7:0] err_count_q, err_count_d;

  logic       cmd_ready_s;
  logic       push_s;
  logic       pop_s;
  logic       issue_s;
  logic [9:0] head_s;
  logic [1:0] head_op_s;
  logic       head_illegal_s;

  // Handshake and FIFO head decode; no bypass when full.
  always_comb begin
    cmd_ready_s    = (count_q < 3'd4);
    push_s         = cmdValid & cmd_ready_s;
    issue_s        = (state_q == ST_ISSUE);
    pop_s          = issue_s;
    head_s         = fifo_q[rd_ptr_q];
    head_op_s      = head_s[9:8];
    head_illegal_s = is_illegal_op(head_op_s);
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    if (push_s) begin
      fifo_d[wr_ptr_q] = {cmdOp, cmdA, cmdB};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Issue FSM; HOLD looks at post-edge occupancy so a same-cycle push counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != 3'd0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (resReady) begin
          if (count_d != 3'd0) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result capture at the end of ISSUE; stage flag is masked for illegal ops.
  always_comb begin
    res_data_d   = res_data_q;
    res_is_and_d = res_is_and_q;
    res_err_d    = res_err_q;
    err_count_d  = err_count_q;
    if (issue_s) begin
      res_data_d   = stageOut;
      res_err_d    = head_illegal_s;
      res_is_and_d = head_illegal_s ? 1'b0 : stageIsAnd;
      if (head_illegal_s && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      res_data_d = res_data_q;
    end
  end

  // Stage drive is gated to the single ISSUE cycle.
  always_comb begin
    if (issue_s) begin
      aIn   = head_s[7:4];
      bIn   = head_s[3:0];
      doAnd = head_op_s[0];
      doOr  = head_op_s[1];
    end else begin
      aIn   = 4'h0;
      bIn   = 4'h0;
      doAnd = 1'b0;
      doOr  = 1'b0;
    end
    cmdReady = cmd_ready_s;
    resValid = (state_q == ST_HOLD);
    resData  = res_data_q;
    resIsAnd = res_is_and_q;
    resErr   = res_err_q;
    errCount = err_count_q;
  end

  // State registers; reset discards in-flight result and queued commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      res_data_q   <= 4'h0;
      res_is_and_q <= 1'b0;
      res_err_q    <= 1'b0;
      err_count_q  <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 10'h000;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_data_q   <= res_data_d;
      res_is_and_q <= res_is_and_d;
      res_err_q    <= res_err_d;
      err_count_q  <= err_count_d;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_logic_op_issuer.sv
// Bench for logic_op_issuer: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_logic_op_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [3:0] cmdA;
  logic [3:0] cmdB;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic       doAnd;
  logic       doOr;
  logic [3:0] stageOut;
  logic       stageIsAnd;
  logic       resValid;
  logic       resReady;
  logic [3:0] resData;
  logic       resIsAnd;
  logic       resErr;
  logic [7:0] errCount;

  logic_op_issuer dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB), .aIn(aIn), .bIn(bIn),
    .doAnd(doAnd), .doOr(doOr), .stageOut(stageOut), .stageIsAnd(stageIsAnd),
    .resValid(resValid), .resReady(resReady), .resData(resData),
    .resIsAnd(resIsAnd), .resErr(resErr), .errCount(errCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stage stub: AND gives (a&b)^B so A,6 -> 9; OR gives a|b; anything else
  // gives a^b. With both selects high the flag is 1, standing in for an
  // unknown value that must be masked.
  function automatic logic [3:0] stub_out(input logic do_and, input logic do_or,
                                          input logic [3:0] a, input logic [3:0] b);
    case ({do_or, do_and})
      2'b01:   return (a & b) ^ 4'hB;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    stageOut   = stub_out(doAnd, doOr, aIn, bIn);
    stageIsAnd = doAnd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t       mq[$];
  cmd_t       m_head;
  int         phase = 0;        // 0 waiting, 1 issuing, 2 holding
  logic [3:0] m_data = 4'h0;
  logic       m_isand = 1'b0;
  logic       m_err = 1'b0;
  int         m_errcnt = 0;
  bit         m_push;
  bit         model_on = 1'b0;

  // Model steps on each rising edge using the inputs present at that edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        phase = 0; m_data = 4'h0; m_isand = 1'b0; m_err = 1'b0; m_errcnt = 0;
      end else begin
        m_push = cmdValid && (mq.size() < 4);
        case (phase)
          0: if (mq.size() > 0) phase = 1;
          1: begin
            m_head  = mq.pop_front();
            m_data  = stub_out(m_head.op[0], m_head.op[1], m_head.a, m_head.b);
            m_err   = (m_head.op == 2'b00) || (m_head.op == 2'b11);
            m_isand = (m_head.op == 2'b01);
            if (m_err && m_errcnt < 255) m_errcnt++;
            phase = 2;
          end
          default: if (resReady) phase = ((mq.size() + int'(m_push)) > 0) ? 1 : 0;
        endcase
        if (m_push) mq.push_back({cmdOp, cmdA, cmdB});
      end
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("cmdReady", 32'(cmdReady), 32'(mq.size() < 4));
        check("resValid", 32'(resValid), 32'(phase == 2));
        check("errCount", 32'(errCount), 32'(m_errcnt));
        if (phase == 1) begin
          check("aIn", 32'(aIn), 32'(mq[0].a));
          check("bIn", 32'(bIn), 32'(mq[0].b));
          check("doAnd", 32'(doAnd), 32'(mq[0].op[0]));
          check("doOr", 32'(doOr), 32'(mq[0].op[1]));
        end else begin
          check("idle_stage_drive", 32'({aIn, bIn, doAnd, doOr}), 32'd0);
        end
        if (phase == 2) begin
          check("resData", 32'(resData), 32'(m_data));
          check("resIsAnd", 32'(resIsAnd), 32'(m_isand));
          check("resErr", 32'(resErr), 32'(m_err));
        end
      end
    end
  end

  // Result stream observer for the throughput scenario.
  bit count_en = 1'b0;
  int pulse_cnt = 0;
  int first_res = -1;
  int last_res = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (count_en && resValid) begin
        if (first_res < 0) first_res = cyc;
        last_res = cyc;
        pulse_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bit ok;
    cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = cmdReady;
      @(posedge clk);
      #1;
      if (ok) begin
        cmdValid = 1'b0;
        return;
      end
    end
    cmdValid = 1'b0;
    check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hold();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (resValid) return;
    end
    check("hold_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (phase == 0 && mq.size() == 0) return;
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmdValid = 1'b0; cmdOp = 2'b00; cmdA = 4'h0; cmdB = 4'h0; resReady = 1'b0;
    @(posedge clk);
    #1 model_on = 1'b1;
    sync();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmdReady", 32'(cmdReady), 32'd1);
    check("rst_resValid", 32'(resValid), 32'd0);
    check("rst_errCount", 32'(errCount), 32'd0);
    check("rst_resData", 32'({resData, resIsAnd, resErr}), 32'd0);

    // Single AND command: 3-edge latency, one-cycle issue and result
    resReady = 1'b1;
    sync();
    push(2'b01, 4'hA, 4'h6);
    @(negedge clk);
    check("lat_idle_valid", 32'(resValid), 32'd0);
    check("lat_idle_doAnd", 32'(doAnd), 32'd0);
    @(negedge clk);
    check("and_aIn", 32'(aIn), 32'hA);
    check("and_bIn", 32'(bIn), 32'h6);
    check("and_doAnd", 32'(doAnd), 32'd1);
    check("and_doOr", 32'(doOr), 32'd0);
    @(negedge clk);
    check("and_resValid", 32'(resValid), 32'd1);
    check("and_resData", 32'(resData), 32'h9);
    check("and_resIsAnd", 32'(resIsAnd), 32'd1);
    check("and_resErr", 32'(resErr), 32'd0);
    @(negedge clk);
    check("and_valid_one_cycle", 32'(resValid), 32'd0);

    // Illegal opcode 11: flag masked, data passed, error counted
    sync();
    push(2'b11, 4'h3, 4'h5);
    @(negedge clk);
    @(negedge clk);
    check("ill_doAnd", 32'(doAnd), 32'd1);
    check("ill_doOr", 32'(doOr), 32'd1);
    @(negedge clk);
    check("ill_resErr", 32'(resErr), 32'd1);
    check("ill_resIsAnd", 32'(resIsAnd), 32'd0);
    check("ill_resData", 32'(resData), 32'h6);
    check("ill_errCount", 32'(errCount), 32'd1);

    // Full FIFO behind a held result; the 5th push waits for the handshake
    sync();
    resReady = 1'b0;
    push(2'b01, 4'h1, 4'h1);
    wait_hold();
    sync();
    for (int i = 0; i < 4; i++) push(2'b10, 4'(i), 4'(15 - i));
    cmdValid = 1'b1; cmdOp = 2'b01; cmdA = 4'hC; cmdB = 4'h7;
    repeat (3) begin
      @(negedge clk);
      check("full_blocks_5th", 32'(cmdReady), 32'd0);
    end
    sync();
    resReady = 1'b1;
    sync();
    resReady = 1'b0;
    @(negedge clk);
    check("full_no_bypass", 32'(cmdReady), 32'd0);
    sync();
    push(2'b01, 4'hC, 4'h7);
    resReady = 1'b1;
    wait_drain();

    // 300 illegal commands saturate the counter
    sync();
    for (int i = 0; i < 300; i++) push((i % 2 == 0) ? 2'b00 : 2'b11, 4'(i), 4'(i >> 4));
    wait_drain();
    check("err_saturated", 32'(errCount), 32'hFF);

    // Reset while holding with 3 queued commands
    sync();
    resReady = 1'b0;
    push(2'b01, 4'h5, 4'h5);
    wait_hold();
    sync();
    for (int i = 0; i < 3; i++) push(2'b01, 4'(i + 1), 4'hF);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_resValid", 32'(resValid), 32'd0);
    check("rst_hold_cmdReady", 32'(cmdReady), 32'd1);
    check("rst_hold_errCount", 32'(errCount), 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("rst_no_issue", 32'({doAnd, doOr, resValid}), 32'd0);
    end

    // Continuous stream across pointer wrap
    resReady = 1'b1;
    sync();
    count_en = 1'b1;
    for (int i = 0; i < 12; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, 4'(i), 4'(15 - i));
    wait_drain();
    count_en = 1'b0;
    check("stream_count", 32'(pulse_cnt), 32'd12);
    check("stream_span", 32'(last_res - first_res), 32'd22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
